triggerrec_event_fifo: RTL

Event buffer for the trigger recorder. It sits directly downstream of the trigger matcher and captures 64-bit event records (timestamp plus trigger index). It presents those records to the control bus as two consecutive 32-bit reads of the event-FIFO register: upper word first, then lower. It also accepts CPU-injected records, written as an upper/lower word pair, so software can test the FIFO path.

---
 rtl/triggerrec_event_fifo.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/triggerrec_event_fifo.sv
// Event buffer between the trigger matcher and the control bus: 64-bit records
// in, read out as two 32-bit halves (upper first), with CPU-injected records.
`timescale 1ns/1ps
module triggerrec_event_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ev_valid,
   input  logic [63:0]   ev_data,
   output logic          ev_ready,
   input  logic          cpu_wr,
   input  logic [31:0]   cpu_wdat,
   input  logic          cpu_rd,
   output logic          cpu_done,
   output logic [31:0]   cpu_rdat,
   input  logic          flush,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full,
   output logic          overflow,
   output logic [7:0]    drop_cnt
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   occ;
   logic          rd_hi;
   logic          wr_hi;
   logic [31:0]   hold_hi;
   logic          pend_valid;
   logic [63:0]   pend_data;
   logic          full_r;
   logic          empty_r;
   logic          done_r;
   logic          ovf_r;
   logic [31:0]   rdat_r;
   logic [7:0]    drops_r;

   logic          rd_op;
   logic          wr_op;
   logic          pop;
   logic          space;
   logic          ev_push;
   logic          ev_drop;
   logic          cpu_second;
   logic [63:0]   cpu_rec;
   logic          cand_valid;
   logic [63:0]   cand_data;
   logic          cand_slot;
   logic          cpu_push;
   logic          cpu_drop;
   logic          lost;
   logic          push;
   logic [63:0]   push_data;
   logic [AW:0]   occ_next;
   logic          pend_valid_next;
   logic [63:0]   pend_data_next;
   logic          done_next;
   logic [1:0]    n_drop;
   logic [8:0]    drop_sum;
   logic [7:0]    drops_next;
   logic [63:0]   rd_word;

   always_comb begin
      rd_op           = cpu_rd;
      wr_op           = cpu_wr & ~cpu_rd;
      rd_word         = mem[rd_ptr];
      pop             = rd_op & rd_hi & ~empty_r;
      // A lower-half read frees a slot in the same cycle, so a full FIFO can
      // still take a push; ev_ready stays the conservative registered !full.
      space           = ~full_r | pop;
      ev_push         = ev_valid & space;
      ev_drop         = ev_valid & ~space;
      cpu_second      = wr_op & wr_hi;
      cpu_rec         = {hold_hi, cpu_wdat};
      cand_valid      = pend_valid | cpu_second;
      cand_data       = pend_valid ? pend_data : cpu_rec;
      cand_slot       = cand_valid & ~ev_push;
      cpu_push        = cand_slot & space;
      cpu_drop        = cand_slot & ~space;
      // Only one CPU record can wait; a third contender is dropped.
      lost            = ev_push & pend_valid & cpu_second;
      push            = ev_push | cpu_push;
      push_data       = ev_push ? ev_data : cand_data;
      occ_next        = occ + (AW+1)'(push) - (AW+1)'(pop);
      pend_valid_next = ev_push ? (pend_valid | cpu_second) : (pend_valid & cpu_second);
      pend_data_next  = (cpu_second && !(ev_push && pend_valid)) ? cpu_rec : pend_data;
      done_next       = rd_op | (wr_op & ~wr_hi) | cand_slot | lost;
      n_drop          = {1'b0, ev_drop} + {1'b0, cpu_drop} + {1'b0, lost};
      drop_sum        = {1'b0, drops_r} + {7'b0, n_drop};
      drops_next      = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (!reset && !flush && push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         rd_hi      <= 1'b0;
         wr_hi      <= 1'b0;
         hold_hi    <= '0;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         ovf_r      <= 1'b0;
         drops_r    <= '0;
         done_r     <= 1'b0;
         rdat_r     <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occ        <= '0;
         rd_hi      <= 1'b0;
         wr_hi      <= 1'b0;
         hold_hi    <= '0;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         ovf_r      <= 1'b0;
         drops_r    <= '0;
         // Coincident bus accesses are discarded but still acknowledged.
         done_r     <= cpu_rd | cpu_wr;
         if (cpu_rd) begin
            rdat_r <= '0;
         end
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         occ     <= occ_next;
         full_r  <= (occ_next == FULL_COUNT);
         empty_r <= (occ_next == '0);
         if (rd_op) begin
            if (empty_r) begin
               rdat_r <= '0;
            end else if (rd_hi) begin
               rdat_r <= rd_word[31:0];
               rd_hi  <= 1'b0;
            end else begin
               rdat_r <= rd_word[63:32];
               rd_hi  <= 1'b1;
            end
         end
         if (wr_op) begin
            if (wr_hi) begin
               wr_hi <= 1'b0;
            end else begin
               hold_hi <= cpu_wdat;
               wr_hi   <= 1'b1;
            end
         end
         pend_valid <= pend_valid_next;
         pend_data  <= pend_data_next;
         done_r     <= done_next;
         if (n_drop != 2'd0) begin
            ovf_r <= 1'b1;
         end
         drops_r <= drops_next;
      end
   end

   assign ev_ready = ~full_r;
   assign cpu_done = done_r;
   assign cpu_rdat = rdat_r;
   assign count    = occ;
   assign empty    = empty_r;
   assign full     = full_r;
   assign overflow = ovf_r;
   assign drop_cnt = drops_r;

endmodule
